vec_accum_reader: RTL

Consumer end of the index-stream interface. An index generator produces a stream of element indices; this block reads each indexed element from a 1-cycle-latency memory and accumulates the values. It checks that indices arrive in order (0, 1, 2, …) and that the stream length matches the expected count, then presents the sum with a one-cycle valid pulse. It sits between the loop-index generator and the downstream datapath of the vector/matrix engine.

---
 rtl/vec_accum_reader.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/vec_accum_reader.sv
// vec_accum_reader: consumes an in-order index stream, reads each indexed
// element from a 1-cycle-latency memory and sums the values. Checks index
// ordering and stream length, then presents the sum with a one-cycle pulse.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for i_start; outputs from the previous run are held
// S_RUN   | accepting index beats and issuing memory reads
// S_DRAIN | two cycles letting the final reads return and accumulate
// S_DONE  | one cycle, o_valid high, o_sum final

module vec_accum_reader #(
    parameter int SIZE_ADDR = 8,
    parameter int SIZE_DATA = 32
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [SIZE_ADDR-1:0]           i_num_elems,
    input  logic                           i_start,
    input  logic                           i_idx_valid,
    input  logic [SIZE_ADDR-1:0]           i_idx,
    input  logic                           i_idx_last,
    output logic                           o_rd_en,
    output logic [SIZE_ADDR-1:0]           o_rd_addr,
    input  logic [SIZE_DATA-1:0]           i_rd_data,
    output logic                           o_busy,
    output logic                           o_valid,
    output logic [SIZE_DATA+SIZE_ADDR-1:0] o_sum,
    output logic [SIZE_ADDR-1:0]           o_count,
    output logic                           o_err
);

    localparam int SUM_W = SIZE_DATA + SIZE_ADDR;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [SIZE_ADDR-1:0] num_elems_q;
    logic [SIZE_ADDR-1:0] exp_idx;
    logic [SIZE_ADDR-1:0] count_inc;
    logic                 drain_cnt;
    logic                 rd_pend;

    logic                 start_ok;
    logic                 beat_ok;
    logic                 seq_bad;
    logic                 over_len;
    logic                 short_len;

    assign start_ok  = (state == S_IDLE) && i_start;
    assign beat_ok   = (state == S_RUN) && i_idx_valid;
    assign count_inc = o_count + 1'b1;

    // A beat past the expected count and a last beat that lands on the wrong
    // count are both length errors; the stream is still fully processed.
    assign seq_bad   = (i_idx != exp_idx);
    assign over_len  = (o_count == num_elems_q);
    assign short_len = i_idx_last && (count_inc != num_elems_q);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt = (i_num_elems == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (i_idx_valid && i_idx_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == 1'b0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs
    always_comb begin
        o_busy  = 1'b0;
        o_valid = 1'b0;
        case (state)
            S_RUN, S_DRAIN: begin
                o_busy = 1'b1;
            end
            S_DONE: begin
                o_busy  = 1'b1;
                o_valid = 1'b1;
            end
            default: begin
                o_busy  = 1'b0;
                o_valid = 1'b0;
            end
        endcase
    end

    // Drain timer: loaded with 1 on the last beat, DONE follows terminal count
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            drain_cnt <= 1'b0;
        end else if (beat_ok && i_idx_last) begin
            drain_cnt <= 1'b1;
        end else if ((state == S_DRAIN) && (drain_cnt != 1'b0)) begin
            drain_cnt <= drain_cnt - 1'b1;
        end
    end

    // Registered memory read port; address holds between beats
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rd_en   <= 1'b0;
            o_rd_addr <= '0;
        end else begin
            o_rd_en <= beat_ok;
            if (beat_ok) begin
                o_rd_addr <= i_idx;
            end
        end
    end

    // Marks the cycle in which i_rd_data carries a requested element
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= o_rd_en;
        end
    end

    // Accumulator; wide enough that 2^SIZE_ADDR-1 maximal elements never wrap
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_sum <= '0;
        end else if (start_ok) begin
            o_sum <= '0;
        end else if (rd_pend) begin
            o_sum <= o_sum + SUM_W'(i_rd_data);
        end
    end

    // Beat bookkeeping: count, expected index (never resyncs) and sticky error
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            num_elems_q <= '0;
            exp_idx     <= '0;
            o_count     <= '0;
            o_err       <= 1'b0;
        end else if (start_ok) begin
            num_elems_q <= i_num_elems;
            exp_idx     <= '0;
            o_count     <= '0;
            o_err       <= 1'b0;
        end else if (beat_ok) begin
            exp_idx <= exp_idx + 1'b1;
            o_count <= count_inc;
            if (seq_bad || over_len || short_len) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule
